// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: per-bar hold/advance/flush decisions for the four
// pipeline register bars and the PC, with memory-wait and halt-drain FSM plus perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             redirect,
  input  logic             mem_halt,
  output logic             en_1,
  output logic             en_2,
  output logic             en_3,
  output logic             en_4,
  output logic             flush_1,
  output logic             flush_2,
  output logic             flush_3,
  output logic             flush_4,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  // Bit 0 of each vector is bar 1 (IF/ID), bit 3 is bar 4 (MEM/WB).
  logic [3:0]       w_en;
  logic [3:0]       w_fl;
  logic             w_pc_en;
  logic             w_inc_flush;
  logic             w_load_use;
  logic             w_mem_busy;

  assign w_load_use = ex_dREN && (ex_wsel != '0) &&
                      ((ex_wsel == id_rs) || (ex_wsel == id_rt));
  assign w_mem_busy = (mem_dREN || mem_dWEN) && !dhit;

  always_comb begin
    w_next      = r_state;
    w_en        = 4'b0000;
    w_fl        = 4'b0000;
    w_pc_en     = 1'b0;
    w_inc_flush = 1'b0;
    case (r_state)
      RUN, MEMWAIT: begin
        // MEMWAIT freezes everything until dhit; on the dhit cycle the RUN
        // priorities apply, and w_mem_busy is already false because dhit=1.
        if (!((r_state == MEMWAIT) && !dhit)) begin
          w_next = RUN;
          if (mem_halt) begin
            w_fl   = 4'b0111;
            w_en   = 4'b1000;
            w_next = DRAIN;
          end else if (w_mem_busy) begin
            w_next = MEMWAIT;
          end else if (redirect) begin
            w_fl        = 4'b0111;
            w_en        = 4'b1000;
            w_pc_en     = 1'b1;
            w_inc_flush = 1'b1;
          end else if (w_load_use) begin
            w_fl = 4'b0010;
            w_en = 4'b1100;
          end else if (!ihit) begin
            w_fl = 4'b0001;
            w_en = 4'b1110;
          end else begin
            w_en    = 4'b1111;
            w_pc_en = 1'b1;
          end
        end
      end
      DRAIN: begin
        w_fl   = 4'b0111;
        w_en   = 4'b1000;
        w_next = HALT;
      end
      HALT: begin
        w_next = HALT;
      end
      default: begin
        w_next = RUN;
      end
    endcase
  end

  // Flush wins over enable; everything is quiet while reset is asserted.
  assign en_1    = nRST & w_en[0] & ~w_fl[0];
  assign en_2    = nRST & w_en[1] & ~w_fl[1];
  assign en_3    = nRST & w_en[2] & ~w_fl[2];
  assign en_4    = nRST & w_en[3] & ~w_fl[3];
  assign flush_1 = nRST & w_fl[0];
  assign flush_2 = nRST & w_fl[1];
  assign flush_3 = nRST & w_fl[2];
  assign flush_4 = nRST & w_fl[3];
  assign pc_en   = nRST & w_pc_en;

  assign halted    = (r_state == HALT);
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign dbg_state = r_state;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (!w_pc_en && (r_state != HALT) && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_inc_flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule
